// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter:
//   arb_state_e : arbiter state (normal CPU-priority mode / locked DBG burst)
//   owner_e     : tag recording which port a pending read belongs to
//   DMEM_ADDR_W / DMEM_DATA_W : default geometry of the 128x32 data memory
// ----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic {
    ST_CPU = 1'b0,
    ST_DBG = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;

endpackage

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the pipeline MEM stage (CPU port)
// and a debug/loader master (DBG port). The CPU has fixed priority; an age
// counter forces a DBG grant after MAX_WAIT refused cycles. A DBG master may
// lock the memory for a burst of up to MAX_BURST grants, during which the
// pipeline is stalled. One memory access per cycle; grant is combinational.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata         CPU access request (from MEM stage)
//   cpu_stall                     CPU request not served this cycle
//   cpu_rdata/cpu_rvalid          CPU read return, one cycle after grant
//   dbg_req/lock/we/addr/wdata    DBG access request, lock asks for a burst
//   dbg_gnt                       DBG access performed this cycle
//   dbg_rdata/dbg_rvalid          DBG read return, one cycle after grant
//   mem_en/we/addr/wdata          strobe and fields to the memory array
//   mem_rdata                     registered memory read data (1-cycle)
// ----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_lock,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  arb_state_e         state;
  arb_state_e         state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_nxt;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_nxt;
  logic               cpu_grant;
  logic               dbg_grant;
  logic               rd_pend;
  owner_e             rd_owner;
  logic [DATA_W-1:0]  cpu_rdata_hold;
  logic [DATA_W-1:0]  dbg_rdata_hold;

  // Grant selection and state/burst next-value logic.
  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    state_nxt = state;
    burst_nxt = burst_cnt;
    case (state)
      ST_CPU: begin
        if (dbg_req && (!cpu_req || (wait_cnt == WAIT_MAX))) begin
          dbg_grant = 1'b1;
        end else if (cpu_req) begin
          cpu_grant = 1'b1;
        end else begin
          cpu_grant = 1'b0;
        end
        if (dbg_grant && dbg_lock) begin
          state_nxt = ST_DBG;
          burst_nxt = BURST_ONE;
        end else begin
          state_nxt = ST_CPU;
          burst_nxt = {BURST_W{1'b0}};
        end
      end
      ST_DBG: begin
        dbg_grant = dbg_req;
        // burst_cnt counts grants already made in the burst; the burst ends
        // on the cycle that performs the MAX_BURST-th grant, so the CPU (with
        // wait_cnt cleared) wins the very next cycle.
        if (!dbg_req || !dbg_lock) begin
          state_nxt = ST_CPU;
          burst_nxt = {BURST_W{1'b0}};
        end else if ((burst_cnt + BURST_ONE) == BURST_MAX) begin
          state_nxt = ST_CPU;
          burst_nxt = {BURST_W{1'b0}};
        end else begin
          state_nxt = ST_DBG;
          burst_nxt = burst_cnt + BURST_ONE;
        end
      end
      default: begin
        state_nxt = ST_CPU;
        burst_nxt = {BURST_W{1'b0}};
      end
    endcase
  end

  // Age counter: counts refused DBG cycles, saturating at MAX_WAIT.
  always_comb begin
    wait_nxt = wait_cnt;
    if (!dbg_req || dbg_grant) begin
      wait_nxt = {WAIT_W{1'b0}};
    end else if (wait_cnt == WAIT_MAX) begin
      wait_nxt = wait_cnt;
    end else begin
      wait_nxt = wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
    end
  end

  // Port handshakes and memory-side mux; everything is quiet during reset.
  always_comb begin
    cpu_stall = !rst && cpu_req && !cpu_grant;
    dbg_gnt   = !rst && dbg_grant;
    mem_en    = !rst && (cpu_grant || dbg_grant);
    if (dbg_grant) begin
      mem_we    = mem_en && dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else begin
      mem_we    = mem_en && cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Arbiter state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CPU;
      wait_cnt  <= {WAIT_W{1'b0}};
      burst_cnt <= {BURST_W{1'b0}};
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Read-return tracking: remember whether a read was granted and for whom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_pend  <= (cpu_grant && !cpu_we) || (dbg_grant && !dbg_we);
      rd_owner <= dbg_grant ? OWN_DBG : OWN_CPU;
    end
  end

  assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
  assign dbg_rvalid = rd_pend && (rd_owner == OWN_DBG);

  // Hold the last returned word per port so rdata stays stable between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata_hold <= {DATA_W{1'b0}};
      dbg_rdata_hold <= {DATA_W{1'b0}};
    end else begin
      if (cpu_rvalid) begin
        cpu_rdata_hold <= mem_rdata;
      end
      if (dbg_rvalid) begin
        dbg_rdata_hold <= mem_rdata;
      end
    end
  end

  // Memory data is already registered, so pass it through in the rvalid cycle.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_hold;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. A behavioural 128x32 memory with a
// registered read port is attached; unwritten words read as 10 + address.
// Inputs change just after the falling edge and outputs are sampled 1 ns
// later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [6:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        dbg_req;
  logic        dbg_lock;
  logic        dbg_we;
  logic [6:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks;
  int failures;

  logic [31:0]  mem [128];
  logic [127:0] written;

  dmem_arbiter #(
    .ADDR_W(7), .DATA_W(32), .MAX_WAIT(4), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory, write-before-read, 1-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      written   <= '0;
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
        mem_rdata         <= mem_wdata;
      end else begin
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : (32'd10 + 32'(mem_addr));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [6:0] addr,
                         input logic [31:0] wdata);
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic set_dbg(input logic req, input logic lock, input logic we,
                         input logic [6:0] addr, input logic [31:0] wdata);
    dbg_req   = req;
    dbg_lock  = lock;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with both requesters active: nothing may leak out.
    rst = 1'b1;
    set_cpu(1'b1, 1'b0, 7'd1, 32'd0);
    set_dbg(1'b1, 1'b0, 1'b0, 7'd2, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_en",     32'(mem_en),     32'd0);
    check("rst_dbg_gnt",    32'(dbg_gnt),    32'd0);
    check("rst_cpu_stall",  32'(cpu_stall),  32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    check("rst_cpu_rdata",  cpu_rdata,       32'd0);
    check("rst_dbg_rdata",  dbg_rdata,       32'd0);

    @(negedge clk);
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, 7'd0, 32'd0);
    set_dbg(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);

    // CPU only: write 0x1234 @5 then read @5 on the next grant.
    @(negedge clk);
    set_cpu(1'b1, 1'b1, 7'd5, 32'h0000_1234);
    #1;
    check("cpu_wr_stall", 32'(cpu_stall), 32'd0);
    check("cpu_wr_en",    32'(mem_en),    32'd1);
    check("cpu_wr_we",    32'(mem_we),    32'd1);
    check("cpu_wr_addr",  32'(mem_addr),  32'd5);
    check("cpu_wr_data",  mem_wdata,      32'h0000_1234);
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 7'd5, 32'd0);
    #1;
    check("cpu_rd_stall",   32'(cpu_stall),  32'd0);
    check("cpu_rd_we",      32'(mem_we),     32'd0);
    check("cpu_wr_norvld",  32'(cpu_rvalid), 32'd0);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 7'd0, 32'd0);
    #1;
    check("cpu_rd_rvalid", 32'(cpu_rvalid), 32'd1);
    check("cpu_rd_data",   cpu_rdata,       32'h0000_1234);
    check("cpu_rd_dbgrv",  32'(dbg_rvalid), 32'd0);
    @(negedge clk);
    #1;
    check("cpu_rv_drop", 32'(cpu_rvalid), 32'd0);
    check("cpu_rd_hold", cpu_rdata,       32'h0000_1234);

    // Idle CPU: DBG read @0 is granted immediately.
    @(negedge clk);
    set_dbg(1'b1, 1'b0, 1'b0, 7'd0, 32'd0);
    #1;
    check("dbg_idle_gnt",  32'(dbg_gnt),  32'd1);
    check("dbg_idle_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    set_dbg(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    #1;
    check("dbg_idle_rvalid", 32'(dbg_rvalid), 32'd1);
    check("dbg_idle_rdata",  dbg_rdata,       32'd10);
    check("dbg_idle_cpurv",  32'(cpu_rvalid), 32'd0);

    // Rvalid routing: CPU read @3 then DBG read @4 back to back.
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 7'd3, 32'd0);
    #1;
    check("route_cpu_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 7'd0, 32'd0);
    set_dbg(1'b1, 1'b0, 1'b0, 7'd4, 32'd0);
    #1;
    check("route_dbg_gnt",   32'(dbg_gnt),    32'd1);
    check("route_cpu_rv",    32'(cpu_rvalid), 32'd1);
    check("route_cpu_data",  cpu_rdata,       32'd13);
    check("route_dbg_rv0",   32'(dbg_rvalid), 32'd0);
    @(negedge clk);
    set_dbg(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    #1;
    check("route_dbg_rv",    32'(dbg_rvalid), 32'd1);
    check("route_dbg_data",  dbg_rdata,       32'd14);
    check("route_cpu_rv0",   32'(cpu_rvalid), 32'd0);
    check("route_cpu_hold",  cpu_rdata,       32'd13);

    // Contention: 4 CPU grants, then a forced DBG grant; repeats.
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      set_cpu(1'b1, 1'b0, 7'd1, 32'd0);
      set_dbg(1'b1, 1'b0, 1'b0, 7'd2, 32'd0);
      #1;
      check($sformatf("cont_gnt_%0d", k),   32'(dbg_gnt),   (k % 5 == 0) ? 32'd1 : 32'd0);
      check($sformatf("cont_stall_%0d", k), 32'(cpu_stall), (k % 5 == 0) ? 32'd1 : 32'd0);
      check($sformatf("cont_addr_%0d", k),  32'(mem_addr),  (k % 5 == 0) ? 32'd2 : 32'd1);
    end
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 7'd0, 32'd0);
    set_dbg(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);

    // Locked burst: 8 DBG grants, one CPU grant, then the burst resumes.
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      set_dbg(1'b1, 1'b1, 1'b0, 7'd20, 32'd0);
      if (k >= 2 && k <= 9) begin
        set_cpu(1'b1, 1'b0, 7'd7, 32'd0);
      end else begin
        set_cpu(1'b0, 1'b0, 7'd0, 32'd0);
      end
      #1;
      check($sformatf("burst_gnt_%0d", k),   32'(dbg_gnt),   (k != 9) ? 32'd1 : 32'd0);
      check($sformatf("burst_stall_%0d", k), 32'(cpu_stall),
            (k >= 2 && k <= 8) ? 32'd1 : 32'd0);
      if (k == 2) begin
        check("burst_dbg_rv",   32'(dbg_rvalid), 32'd1);
        check("burst_dbg_data", dbg_rdata,       32'd30);
      end
    end

    // Reset mid-burst: pending DBG read dropped, outputs quiet immediately.
    @(negedge clk);
    rst = 1'b1;
    set_cpu(1'b1, 1'b0, 7'd7, 32'd0);
    #1;
    check("rstb_dbg_rv",   32'(dbg_rvalid), 32'd0);
    check("rstb_cpu_rv",   32'(cpu_rvalid), 32'd0);
    check("rstb_mem_en",   32'(mem_en),     32'd0);
    check("rstb_dbg_gnt",  32'(dbg_gnt),    32'd0);
    check("rstb_stall",    32'(cpu_stall),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    // Back in ST_CPU: the CPU beats a locked DBG request.
    check("rstb_state_dbg", 32'(dbg_gnt),   32'd0);
    check("rstb_state_cpu", 32'(cpu_stall), 32'd0);
    check("rstb_state_adr", 32'(mem_addr),  32'd7);

    @(negedge clk);
    set_cpu(1'b0, 1'b0, 7'd0, 32'd0);
    set_dbg(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
